// File: rtl/fifo_sync_lvl_pkg.sv
// Shared sizing helpers and reset constants for the fifo_sync_lvl FIFO.
package fifo_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers need at least one bit even for DEPTH values where clog2 collapses.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam logic RST_DATA_BIT = 1'b0;

endpackage

// File: rtl/fifo_sync_lvl_if.sv
// Producer/consumer bus of fifo_sync_lvl; error flag signals exist only with FIFO_ERR_FLAGS_EN.
interface fifo_sync_lvl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    parameter int CW    = count_width(DEPTH)
);
    logic             i_Flush;
    logic             i_Wr_DV;
    logic [WIDTH-1:0] i_Wr_Data;
    logic [CW-1:0]    i_AF_Level;
    logic             o_AF_Flag;
    logic             o_Full;
    logic             i_Rd_En;
    logic             o_Rd_DV;
    logic [WIDTH-1:0] o_Rd_Data;
    logic [CW-1:0]    i_AE_Level;
    logic             o_AE_Flag;
    logic             o_Empty;
    logic [CW-1:0]    o_Count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             o_Wr_Ovf;
    logic             o_Rd_Unf;

    modport slave (
        input  i_Flush, i_Wr_DV, i_Wr_Data, i_AF_Level, i_Rd_En, i_AE_Level,
        output o_AF_Flag, o_Full, o_Rd_DV, o_Rd_Data, o_AE_Flag, o_Empty, o_Count,
        output o_Wr_Ovf, o_Rd_Unf
    );
    modport master (
        output i_Flush, i_Wr_DV, i_Wr_Data, i_AF_Level, i_Rd_En, i_AE_Level,
        input  o_AF_Flag, o_Full, o_Rd_DV, o_Rd_Data, o_AE_Flag, o_Empty, o_Count,
        input  o_Wr_Ovf, o_Rd_Unf
    );
`else
    modport slave (
        input  i_Flush, i_Wr_DV, i_Wr_Data, i_AF_Level, i_Rd_En, i_AE_Level,
        output o_AF_Flag, o_Full, o_Rd_DV, o_Rd_Data, o_AE_Flag, o_Empty, o_Count
    );
    modport master (
        output i_Flush, i_Wr_DV, i_Wr_Data, i_AF_Level, i_Rd_En, i_AE_Level,
        input  o_AF_Flag, o_Full, o_Rd_DV, o_Rd_Data, o_AE_Flag, o_Empty, o_Count
    );
`endif
endinterface

// File: rtl/fifo_sync_lvl_ptr_wrap.sv
// Wrapping FIFO pointer: increments on enable, wraps DEPTH-1 -> 0, synchronous clear.
module fifo_ptr_wrap #(
    parameter int DEPTH = 5,
    parameter int PW    = 3
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Clr,
    input  logic          i_Inc,
    output logic [PW-1:0] o_Ptr
);
    logic [PW-1:0] ptr_q, ptr_d;

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_comb begin
        ptr_d = ptr_q;
        if (i_Clr) begin
            ptr_d = '0;
        end else if (i_Inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign o_Ptr = ptr_q;
endmodule

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with any DEPTH, FWFT/standard read, level flags and flush.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 5,
    parameter int MAKE_FWFT = 1,
    localparam int CW       = count_width(DEPTH),
    localparam int PW       = ptr_width(DEPTH)
) (
    input logic            i_Clk,
    input logic            i_Rst,
    fifo_sync_lvl_if.slave bus
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_dv_q, rd_dv_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, empty, rd_accept, wr_accept;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush wins over any same-cycle access; a read frees a slot for a write when full.
    assign rd_accept = bus.i_Rd_En && !empty && !bus.i_Flush;
    assign wr_accept = bus.i_Wr_DV && (!full || rd_accept) && !bus.i_Flush;

    always_comb begin
        count_d   = count_q + CW'(wr_accept) - CW'(rd_accept);
        rd_dv_d   = rd_accept;
        rd_data_d = rd_data_q;
        if (rd_accept) rd_data_d = mem_q[rd_ptr];
        if (bus.i_Flush) begin
            count_d   = '0;
            rd_data_d = {WIDTH{RST_DATA_BIT}};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count_q   <= '0;
            rd_dv_q   <= 1'b0;
            rd_data_q <= {WIDTH{RST_DATA_BIT}};
        end else begin
            count_q   <= count_d;
            rd_dv_q   <= rd_dv_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst && wr_accept) mem_q[wr_ptr] <= bus.i_Wr_Data;
    end

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Clr (bus.i_Flush),
        .i_Inc (wr_accept),
        .o_Ptr (wr_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_Clr (bus.i_Flush),
        .i_Inc (rd_accept),
        .o_Ptr (rd_ptr)
    );

    // FWFT shows the head while data is present and falls back to the last popped word.
    always_comb begin
        bus.o_Rd_Data = rd_data_q;
        if (MAKE_FWFT != 0 && !empty) bus.o_Rd_Data = mem_q[rd_ptr];
    end

    assign bus.o_Rd_DV   = rd_dv_q;
    assign bus.o_Count   = count_q;
    assign bus.o_Empty   = empty;
    assign bus.o_Full    = full;
    assign bus.o_AF_Flag = (count_q >= bus.i_AF_Level);
    assign bus.o_AE_Flag = (count_q <= bus.i_AE_Level);

`ifdef FIFO_ERR_FLAGS_EN
    logic wr_ovf_q, wr_ovf_d, rd_unf_q, rd_unf_d;

    always_comb begin
        wr_ovf_d = wr_ovf_q;
        rd_unf_d = rd_unf_q;
        if (!bus.i_Flush) begin
            if (bus.i_Wr_DV && !wr_accept) wr_ovf_d = 1'b1;
            if (bus.i_Rd_En && !rd_accept) rd_unf_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ovf_q <= 1'b0;
            rd_unf_q <= 1'b0;
        end else begin
            wr_ovf_q <= wr_ovf_d;
            rd_unf_q <= rd_unf_d;
        end
    end

    assign bus.o_Wr_Ovf = wr_ovf_q;
    assign bus.o_Rd_Unf = rd_unf_q;
`endif
endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl: one FWFT instance and one standard-mode instance.
module tb_fifo_sync_lvl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_lvl_if #(.WIDTH(8), .DEPTH(5)) f_if ();
    fifo_sync_lvl_if #(.WIDTH(8), .DEPTH(5)) s_if ();

    fifo_sync_lvl #(.WIDTH(8), .DEPTH(5), .MAKE_FWFT(1)) u_fwft (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (f_if.slave)
    );

    fifo_sync_lvl #(.WIDTH(8), .DEPTH(5), .MAKE_FWFT(0)) u_std (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (s_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        f_if.i_Flush = 0; f_if.i_Wr_DV = 0; f_if.i_Wr_Data = 0; f_if.i_Rd_En = 0;
        f_if.i_AF_Level = 3'd4; f_if.i_AE_Level = 3'd1;
        s_if.i_Flush = 0; s_if.i_Wr_DV = 0; s_if.i_Wr_Data = 0; s_if.i_Rd_En = 0;
        s_if.i_AF_Level = 3'd4; s_if.i_AE_Level = 3'd1;

        // reset state
        rst = 1; tick(); tick(); rst = 0;
        check("rst_count", f_if.o_Count, 0);
        check("rst_empty", f_if.o_Empty, 1);
        check("rst_full", f_if.o_Full, 0);
        check("rst_rd_dv", f_if.o_Rd_DV, 0);
        check("rst_rd_data", f_if.o_Rd_Data, 0);
        check("rst_ae", f_if.o_AE_Flag, 1);
        check("rst_af_lvl4", f_if.o_AF_Flag, 0);
        f_if.i_AF_Level = 3'd0; #1;
        check("rst_af_lvl0", f_if.o_AF_Flag, 1);
        f_if.i_AF_Level = 3'd4; #1;
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_ovf", f_if.o_Wr_Ovf, 0);
        check("rst_unf", f_if.o_Rd_Unf, 0);
`endif

        // single word fall-through
        f_if.i_Wr_DV = 1; f_if.i_Wr_Data = 8'hAB; tick(); f_if.i_Wr_DV = 0;
        check("wab_empty", f_if.o_Empty, 0);
        check("wab_count", f_if.o_Count, 1);
        check("wab_data", f_if.o_Rd_Data, 8'hAB);
        check("wab_dv", f_if.o_Rd_DV, 0);
        f_if.i_Rd_En = 1; tick(); f_if.i_Rd_En = 0;
        check("rab_dv", f_if.o_Rd_DV, 1);
        check("rab_empty", f_if.o_Empty, 1);
        check("rab_data", f_if.o_Rd_Data, 8'hAB);
        tick();
        check("rab_dv_pulse", f_if.o_Rd_DV, 0);

        // three fill/drain rounds to walk the pointers through the wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 5; i++) begin
                f_if.i_Wr_DV = 1; f_if.i_Wr_Data = 8'(i); tick();
                check("fill_count", f_if.o_Count, 32'(i));
                check("fill_ae", f_if.o_AE_Flag, (i <= 1) ? 1 : 0);
                check("fill_af", f_if.o_AF_Flag, (i >= 4) ? 1 : 0);
                check("fill_full", f_if.o_Full, (i == 5) ? 1 : 0);
            end
            f_if.i_Wr_Data = 8'h06; tick(); f_if.i_Wr_DV = 0;
            check("drop_count", f_if.o_Count, 5);
            check("drop_head", f_if.o_Rd_Data, 8'h01);
`ifdef FIFO_ERR_FLAGS_EN
            check("drop_ovf", f_if.o_Wr_Ovf, 1);
`endif
            for (int i = 1; i <= 5; i++) begin
                f_if.i_Rd_En = 1; #1;
                check("drain_head", f_if.o_Rd_Data, 32'(i));
                tick();
                check("drain_dv", f_if.o_Rd_DV, 1);
                check("drain_count", f_if.o_Count, 32'(5 - i));
            end
            f_if.i_Rd_En = 0;
            check("drain_empty", f_if.o_Empty, 1);
            check("drain_last", f_if.o_Rd_Data, 8'h05);
            check("drain_ae", f_if.o_AE_Flag, 1);
            check("drain_af", f_if.o_AF_Flag, 0);
        end
`ifdef FIFO_ERR_FLAGS_EN
        check("no_unf_yet", f_if.o_Rd_Unf, 0);
`endif

        // full FIFO with simultaneous write and read
        for (int i = 1; i <= 5; i++) begin
            f_if.i_Wr_DV = 1; f_if.i_Wr_Data = 8'(i); tick();
        end
        f_if.i_Wr_Data = 8'h54; f_if.i_Rd_En = 1; tick();
        f_if.i_Wr_DV = 0; f_if.i_Rd_En = 0;
        check("fullrw_count", f_if.o_Count, 5);
        check("fullrw_dv", f_if.o_Rd_DV, 1);
        check("fullrw_head", f_if.o_Rd_Data, 8'h02);
        f_if.i_Rd_En = 1;
        for (int i = 2; i <= 5; i++) begin
            #1; check("fullrw_order", f_if.o_Rd_Data, 32'(i)); tick();
        end
        #1; check("fullrw_last", f_if.o_Rd_Data, 8'h54); tick();
        f_if.i_Rd_En = 0;
        check("fullrw_empty", f_if.o_Empty, 1);

        // flush beats a same-cycle write
        for (int i = 0; i < 3; i++) begin
            f_if.i_Wr_DV = 1; f_if.i_Wr_Data = 8'hA0 + 8'(i); tick();
        end
        check("preflush_count", f_if.o_Count, 3);
        f_if.i_Flush = 1; f_if.i_Wr_Data = 8'hEE; tick();
        f_if.i_Flush = 0; f_if.i_Wr_DV = 0;
        check("flush_count", f_if.o_Count, 0);
        check("flush_empty", f_if.o_Empty, 1);
        check("flush_data", f_if.o_Rd_Data, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("flush_ovf_kept", f_if.o_Wr_Ovf, 1);
        check("flush_unf_kept", f_if.o_Rd_Unf, 0);
`endif
        tick();
        check("flush_nowrite", f_if.o_Count, 0);

        // read on empty, plus write on empty with a read that must be ignored
        f_if.i_Rd_En = 1; tick();
        check("unf_dv", f_if.o_Rd_DV, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf_set", f_if.o_Rd_Unf, 1);
`endif
        f_if.i_Wr_DV = 1; f_if.i_Wr_Data = 8'h77; tick();
        f_if.i_Wr_DV = 0; f_if.i_Rd_En = 0;
        check("emptyrw_count", f_if.o_Count, 1);
        check("emptyrw_dv", f_if.o_Rd_DV, 0);
        check("emptyrw_data", f_if.o_Rd_Data, 8'h77);

        // reset mid-operation discards contents and clears errors
        rst = 1; tick(); rst = 0;
        check("rst2_count", f_if.o_Count, 0);
        check("rst2_data", f_if.o_Rd_Data, 0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst2_ovf", f_if.o_Wr_Ovf, 0);
        check("rst2_unf", f_if.o_Rd_Unf, 0);
`endif

        // standard read mode
        s_if.i_Wr_DV = 1; s_if.i_Wr_Data = 8'h11; tick();
        s_if.i_Wr_Data = 8'h22; tick(); s_if.i_Wr_DV = 0;
        check("std_count", s_if.o_Count, 2);
        check("std_no_fall", s_if.o_Rd_Data, 0);
        s_if.i_Rd_En = 1; tick();
        check("std_dv1", s_if.o_Rd_DV, 1);
        check("std_data1", s_if.o_Rd_Data, 8'h11);
        tick();
        check("std_dv2", s_if.o_Rd_DV, 1);
        check("std_data2", s_if.o_Rd_Data, 8'h22);
        check("std_empty", s_if.o_Empty, 1);
        tick(); s_if.i_Rd_En = 0;
        check("std_unf_dv", s_if.o_Rd_DV, 0);
        check("std_hold", s_if.o_Rd_Data, 8'h22);
`ifdef FIFO_ERR_FLAGS_EN
        check("std_unf", s_if.o_Rd_Unf, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
